// File: rtl/sdram_ctrl_if_if.sv
// Host command bus into sdram_ctrl_if: 3-bit encoded command plus address over valid/ready.
interface sdram_ctrl_if_if #(
  parameter int ASIZE = 23
);
  logic [2:0]       CMD;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [ASIZE-1:0] ADDR;

  modport master (output CMD, CMD_VALID, ADDR, input CMD_READY);
  modport slave  (input CMD, CMD_VALID, ADDR, output CMD_READY);
endinterface

// File: rtl/sdram_ctrl_if.sv
// SDRAM controller host front end: command decode to held strobes, refresh timer, power-up init.
// Power-up sequence (IWAIT/IPRE/IREF/ILMR) is built only when SDRAM_AUTO_INIT_EN is defined.
//
// state | meaning
// IWAIT | power-up wait, counting INIT_PER cycles
// IPRE  | init PRECHARGE held until CM_ACK
// IREF  | init REFRESH held until CM_ACK, INIT_REFS times
// ILMR  | init LOAD_MODE with SADDR = MODE_REG held until CM_ACK
// IDLE  | CMD_READY high, accepting host commands
// BUSY  | strobe held until CM_ACK
module sdram_ctrl_if #(
  parameter int               ASIZE     = 23,
  parameter logic [15:0]      REF_PER   = 16'd1560,
  parameter logic [15:0]      INIT_PER  = 16'd20000,
  parameter logic [3:0]       INIT_REFS = 4'd8,
  parameter logic [ASIZE-1:0] MODE_REG  = 'h037
) (
  input  logic             CLK,
  input  logic             RESET_N,
  sdram_ctrl_if_if.slave   host,
  input  logic             CM_ACK,
  input  logic             REF_ACK,
  output logic             NOP,
  output logic             READA,
  output logic             WRITEA,
  output logic             REFRESH,
  output logic             PRECHARGE,
  output logic             LOAD_MODE,
  output logic [ASIZE-1:0] SADDR,
  output logic             REF_REQ,
  output logic             INIT_REQ,
  output logic             INIT_DONE
);

  localparam int C_NOP = 0;
`ifdef SDRAM_AUTO_INIT_EN
  localparam int C_REF = 3;
  localparam int C_PRE = 4;
  localparam int C_LMR = 5;

  typedef enum logic [2:0] {S_IWAIT, S_IPRE, S_IREF, S_ILMR, S_IDLE, S_BUSY} state_t;
  localparam state_t S_RST = S_IWAIT;

  logic [15:0] init_cnt;
  logic [3:0]  refs_left;
`else
  typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;
  localparam state_t S_RST = S_IDLE;

  logic unused_cfg;
  assign unused_cfg = ^{INIT_PER, INIT_REFS, MODE_REG};
  assign INIT_REQ   = 1'b0;
`endif

  state_t      state;
  logic [5:0]  strb;    // one-hot, bit index equals the command code
  logic [15:0] ref_cnt;
  logic        cmd_ready;

  assign cmd_ready      = (state == S_IDLE) && INIT_DONE;
  assign host.CMD_READY = cmd_ready;
  assign {LOAD_MODE, PRECHARGE, REFRESH, WRITEA, READA, NOP} = strb;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= S_RST;
      strb      <= '0;
      SADDR     <= '0;
      INIT_DONE <= 1'b0;
`ifdef SDRAM_AUTO_INIT_EN
      INIT_REQ  <= 1'b0;
      init_cnt  <= INIT_PER;
      refs_left <= INIT_REFS;
`endif
    end else begin
      strb[C_NOP] <= 1'b0;
      case (state)
`ifdef SDRAM_AUTO_INIT_EN
        S_IWAIT: begin
          if (init_cnt <= 16'd1) begin
            state    <= S_IPRE;
            INIT_REQ <= 1'b1;
          end else begin
            init_cnt <= init_cnt - 16'd1;
          end
        end
        // Each init step raises its strobe on entry, so an ack only counts once the strobe is up.
        S_IPRE: begin
          if (!strb[C_PRE]) begin
            strb[C_PRE] <= 1'b1;
          end else if (CM_ACK) begin
            strb[C_PRE] <= 1'b0;
            refs_left   <= INIT_REFS;
            state       <= S_IREF;
          end
        end
        S_IREF: begin
          if (!strb[C_REF]) begin
            strb[C_REF] <= 1'b1;
          end else if (CM_ACK) begin
            strb[C_REF] <= 1'b0;
            if (refs_left <= 4'd1) state <= S_ILMR;
            else refs_left <= refs_left - 4'd1;
          end
        end
        S_ILMR: begin
          if (!strb[C_LMR]) begin
            strb[C_LMR] <= 1'b1;
            SADDR       <= MODE_REG;
          end else if (CM_ACK) begin
            strb[C_LMR] <= 1'b0;
            INIT_REQ    <= 1'b0;
            INIT_DONE   <= 1'b1;
            state       <= S_IDLE;
          end
        end
`endif
        S_IDLE: begin
`ifndef SDRAM_AUTO_INIT_EN
          INIT_DONE <= 1'b1;
`endif
          if (host.CMD_VALID && cmd_ready) begin
            SADDR <= host.ADDR;
            case (host.CMD)
              3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
                strb  <= 6'd1 << host.CMD;
                state <= S_BUSY;
              end
              default: strb[C_NOP] <= 1'b1;
            endcase
          end
        end
        S_BUSY: begin
          if (CM_ACK) begin
            strb  <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          strb  <= '0;
          state <= S_RST;
        end
      endcase
    end
  end

  // Expiry wins over a coincident REF_ACK so no refresh interval is lost.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ref_cnt <= REF_PER;
      REF_REQ <= 1'b0;
    end else if (INIT_DONE) begin
      if (ref_cnt <= 16'd1) begin
        ref_cnt <= REF_PER;
        REF_REQ <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt - 16'd1;
        if (REF_ACK) REF_REQ <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sdram_ctrl_if.md
# sdram_ctrl_if

Host-facing front end of the SDRAM controller, directly upstream of the command sequencer. Accepts encoded host commands over a valid/ready handshake and decodes them into one-hot command strobes (NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE). Registers the host address as SADDR and holds each strobe until the sequencer returns CM_ACK. Also owns the periodic refresh timer (REF_REQ/REF_ACK) and the optional power-up initialisation sequence (INIT_REQ).

## Interface
- ASIZE, 23, host/SADDR address width
- REF_PER, 1560, refresh interval in CLK cycles (16-bit)
- INIT_PER, 20000, power-up wait in CLK cycles (16-bit)
- INIT_REFS, 8, refreshes issued during init (1..15)
- MODE_REG, 'h037, mode-register value driven on SADDR during init LOAD_MODE, zero-extended to ASIZE
- CLK  in  1  system clock; all logic on rising edge
- RESET_N  in  1  synchronous, active-low reset
- CMD  in  3  host command: 0 NOP, 1 READA, 2 WRITEA, 3 REFRESH, 4 PRECHARGE, 5 LOAD_MODE, 6/7 reserved (treated as NOP)
- CMD_VALID  in  1  host command valid
- CMD_READY  out  1  block can accept a command
- ADDR  in  ASIZE  host address, captured with the command
- CM_ACK  in  1  sequencer command acknowledge
- REF_ACK  in  1  sequencer refresh acknowledge
- NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE  out  1 each  decoded strobes, at most one high
- SADDR  out  ASIZE  registered address
- REF_REQ  out  1  refresh request
- INIT_REQ  out  1  initialisation in progress
- INIT_DONE  out  1  init complete, host path enabled

## Operation
- Reset: all strobes, SADDR, REF_REQ, INIT_REQ, INIT_DONE and CMD_READY are 0. Refresh counter loads REF_PER. FSM enters IWAIT.
- FSM states are IWAIT, IPRE, IREF, ILMR, IDLE and BUSY.
- IWAIT: count down INIT_PER cycles, then go to IPRE and set INIT_REQ.
- IPRE: hold PRECHARGE until CM_ACK, then go to IREF.
- IREF: hold REFRESH until CM_ACK. Repeat INIT_REFS times (4-bit counter), then go to ILMR.
- ILMR: hold LOAD_MODE with SADDR = MODE_REG until CM_ACK. Then clear INIT_REQ, set INIT_DONE and go to IDLE.
- IDLE: CMD_READY = 1.
  - On CMD_VALID & CMD_READY: latch ADDR into SADDR and decode CMD.
  - Codes 1–5: assert the matching strobe and go to BUSY.
  - NOP or reserved code: NOP high for exactly one cycle, stay in IDLE, CMD_READY stays 1.
- BUSY: CMD_READY = 0 and the strobe is held. On CM_ACK, drop the strobe and return to IDLE.
- CM_ACK outside IPRE/IREF/ILMR/BUSY is ignored.
- Refresh timer:
  - Runs only when INIT_DONE = 1. Decrements every cycle.
  - At 0: set REF_REQ and reload REF_PER.
  - REF_REQ stays high until REF_ACK.
  - Expiry in the same cycle as REF_ACK: REF_REQ stays 1.
  - REF_ACK while REF_REQ = 0 is ignored.
- Reset asserted mid-operation (any state) returns to the reset condition on the next edge. A pending strobe is dropped with no ack required.

## Timing
- Command accept at edge N: strobe and SADDR valid from N+1; CMD_READY low from N+1.
- CM_ACK sampled at edge M: strobe low from M+1; CMD_READY high from M+1. The next command can be accepted at M+1, so peak throughput is one command per 2 cycles.
- CM_ACK in the same cycle a strobe first rises is honoured: the strobe is high for exactly 1 cycle.
- IWAIT exit is INIT_PER cycles after RESET_N deasserts. PRECHARGE rises on the following edge.
- REF_REQ rises REF_PER cycles after INIT_DONE rises, and every REF_PER cycles thereafter, independent of REF_ACK timing.
- All outputs are registered; no combinational input-to-output paths. The exception is CMD_READY, which is decoded from the FSM state register.

## Configuration
- SDRAM_AUTO_INIT_EN defined: power-up sequence as described above (IWAIT → IPRE → IREF → ILMR → IDLE).
- SDRAM_AUTO_INIT_EN undefined:
  - IWAIT, IPRE, IREF and ILMR are not built; reset enters IDLE.
  - INIT_REQ is tied to 0.
  - INIT_DONE = 1 from the first cycle after reset.
  - The refresh timer runs immediately after reset.
  - The host issues PRECHARGE, REFRESH and LOAD_MODE itself.

## Test plan
- Auto-init with INIT_PER=10, INIT_REFS=2, sequencer acking 2 cycles after each strobe:
  - PRECHARGE rises at cycle 11 after reset release, then 2× REFRESH, then LOAD_MODE with SADDR='h037.
  - INIT_DONE=1 and INIT_REQ=0 after the last ack.
- READA with ADDR='h12345 accepted; CM_ACK 4 cycles later:
  - READA high for exactly 4 cycles with SADDR='h12345.
  - CMD_READY low for those 4 cycles, high the next cycle.
- CMD=7 with CMD_VALID held for 3 cycles → NOP high for 3 consecutive cycles; CMD_READY stays 1; no other strobe.
- REF_PER=16, REF_ACK never driven → REF_REQ rises 16 cycles after INIT_DONE and stays high. Pulse REF_ACK on an expiry cycle → REF_REQ stays 1.
- RESET_N low for 1 cycle while WRITEA is held → all outputs 0 next cycle and the FSM is in IWAIT; a stray CM_ACK afterwards has no effect.
- Build without SDRAM_AUTO_INIT_EN → CMD_READY=1 and INIT_DONE=1 one cycle after reset release; INIT_REQ is never 1.
